// File: rtl/clock_pkg.sv
// Shared constants for the digital clock time keeper:
// mode encodings, seven-segment table and a BCD split helper.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int         SEG_DP    = 7;
  localparam logic [7:0] DP_MASK   = 8'(1 << SEG_DP);

  // Active-high, bits 6:0 = g..a, entry n is digit n
  localparam logic [0:9][7:0] SEG_TABLE = {
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  // Split 0..63 into {tens, units} by repeated compare/subtract
  function automatic logic [7:0] split_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

endpackage

// File: rtl/clock_time_keeper_seg7.sv
// seg7_encode: BCD digit to active-high seven-segment pattern.
// Blank input or a non-decimal code gives an all-off pattern.
module seg7_encode
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg
);

  // Table lookup with blanking
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// clock_time_keeper: 24-hour HH:MM keeper with two-button setting.
// Optional macro SET_BLINK_EN blanks the field being set for half a second.
module clock_time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] led1_out,
  output logic [7:0] led2_out,
  output logic [7:0] led3_out,
  output logic [7:0] led4_out,
  output logic [1:0] mode,
  output logic       sec_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_DIV / 2);

  logic [PW-1:0] presc;
  logic [5:0]    sec;
  logic [5:0]    min;
  logic [4:0]    hr;
  mode_t         state;
  mode_t         state_nxt;
  logic          mode_prev;
  logic          inc_prev;

  logic wrap;
  logic half;
  logic mode_press;
  logic inc_press;
  logic run_resume;

  assign wrap       = (presc == LAST);
  assign half       = (presc < HALF);
  assign mode_press = btn_mode & ~mode_prev;
  assign inc_press  = btn_inc & ~inc_prev & ~mode_press;
  assign run_resume = mode_press && (state == MODE_SET_MIN);

  // Button history; reset high so a held button is not a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
    end
  end

  // Prescaler, restarted when leaving SET_MIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= wrap;
      if (run_resume || wrap) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Mode state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MODE_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Mode next-state: RUN -> SET_HOUR -> SET_MIN -> RUN
  always_comb begin
    state_nxt = state;
    if (mode_press) begin
      case (state)
        MODE_RUN:      state_nxt = MODE_SET_HOUR;
        MODE_SET_HOUR: state_nxt = MODE_SET_MIN;
        default:       state_nxt = MODE_RUN;
      endcase
    end
  end

  // Time counters: advance in RUN, manual increment in SET modes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec <= '0;
      min <= '0;
      hr  <= '0;
    end else begin
      if ((state == MODE_RUN) && wrap) begin
        if (sec == 6'd59) begin
          sec <= '0;
          if (min == 6'd59) begin
            min <= '0;
            hr  <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
          end else begin
            min <= min + 6'd1;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end
      if (run_resume) begin
        sec <= '0;
      end
      if (inc_press && (state == MODE_SET_HOUR)) begin
        hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
      end
      if (inc_press && (state == MODE_SET_MIN)) begin
        min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
      end
    end
  end

  logic [7:0] hr_bcd;
  logic [7:0] min_bcd;
  logic       blank_hr;
  logic       blank_min;
  logic       dp;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic [7:0] seg4;

  assign hr_bcd  = split_bcd({1'b0, hr});
  assign min_bcd = split_bcd(min);
  assign dp      = (state == MODE_RUN) && half;

`ifdef SET_BLINK_EN
  assign blank_hr  = (state == MODE_SET_HOUR) && !half;
  assign blank_min = (state == MODE_SET_MIN) && !half;
`else
  assign blank_hr  = 1'b0;
  assign blank_min = 1'b0;
`endif

  seg7_encode u_seg1 (
    .bcd   (hr_bcd[7:4]),
    .blank (blank_hr),
    .seg   (seg1)
  );

  seg7_encode u_seg2 (
    .bcd   (hr_bcd[3:0]),
    .blank (blank_hr),
    .seg   (seg2)
  );

  seg7_encode u_seg3 (
    .bcd   (min_bcd[7:4]),
    .blank (blank_min),
    .seg   (seg3)
  );

  seg7_encode u_seg4 (
    .bcd   (min_bcd[3:0]),
    .blank (blank_min),
    .seg   (seg4)
  );

  // Registered display and mode outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led1_out <= SEG_TABLE[0];
      led2_out <= SEG_TABLE[0];
      led3_out <= SEG_TABLE[0];
      led4_out <= SEG_TABLE[0];
      mode     <= MODE_RUN;
    end else begin
      led1_out <= seg1;
      led2_out <= dp ? (seg2 | DP_MASK) : seg2;
      led3_out <= seg3;
      led4_out <= seg4;
      mode     <= state;
    end
  end

endmodule

// File: doc/clock_time_keeper.md
Name: clock_time_keeper

Overview:
- Upstream stage of the display multiplexer in the digital clock.
- Keeps 24-hour time (HH:MM, with internal seconds) from a prescaled 1 Hz tick, and handles two-button time setting.
- Encodes the four digits as 8-bit seven-segment patterns for the multiplexer's four digit inputs.

Parameters:
- CLK_DIV, 50000000, clk cycles per second (≥2). Benches use 4.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset, asynchronous, active-high.
- btn_mode  input  1  mode button level; already debounced and synchronous to clk.
- btn_inc  input  1  increment button level; already debounced and synchronous to clk.
- led1_out  output  8  hour-tens segment pattern.
- led2_out  output  8  hour-units segment pattern; bit 7 is the blinking colon DP.
- led3_out  output  8  minute-tens segment pattern.
- led4_out  output  8  minute-units segment pattern.
- mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN.
- sec_tick  output  1  one-cycle pulse per prescaler wrap.

Behaviour:
- **Segment format**
  - Active-high. Bits 6:0 = g..a; bit 7 = DP.
  - Codes 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. Blank = 00.
- **Reset** (async assert, sync release): prescaler=0, sec=0, min=0, hr=0, mode=RUN, sec_tick=0, all ledN_out=3F (shows 00:00, DP off).
  - Edge-detect registers reset to 1, so a button held through reset is not a press.
- **Prescaler**
  - Counts 0..CLK_DIV-1 and runs in every mode.
  - At count CLK_DIV-1 it wraps to 0, and sec_tick=1 in the following cycle.
  - half = (prescaler < CLK_DIV/2), integer division.
- **Time advance** (RUN only, on a wrap):
  - sec 59→0 carries to min; min 59→0 carries to hr; hr 23→0.
  - 23:59:59 → 00:00:00.
  - In SET modes, wraps do not change hr/min/sec.
- **Button press** = rising edge (level 1 while previous sample 0), one per press regardless of hold length.
- **Mode FSM**
  - Mode press: RUN→SET_HOUR→SET_MIN→RUN.
  - On SET_MIN→RUN: sec=0 and prescaler=0, so a full second elapses before the first advance.
- **Increment**
  - An inc press in SET_HOUR increments hr (23→0); in SET_MIN it increments min (59→0, no carry into hr).
  - An inc press in RUN is ignored.
- **Simultaneous events**
  - Mode and inc pressed in the same cycle: mode acts, inc is discarded.
  - Mode press coincident with a prescaler wrap in RUN: the advance applies, then the mode changes.
- **Digit split:** hr/10, hr%10, min/10, min%10 via small compare/subtract; no divider.
- **DP:** led2_out[7] = half in RUN; 0 in SET modes. All other DP bits are 0.
- **Output timing:** ledN_out and mode are registered, with 1-cycle latency from the internal state change.

Optional Feature:
- Macro SET_BLINK_EN.
- When defined: in SET_HOUR, led1/led2 show blank (00) while half=0; in SET_MIN, led3/led4 do likewise. The non-selected field is always shown.
- When undefined: the selected field is always displayed, with no blanking.
- FSM and time behaviour are identical in both cases.

Decomposition:
- Shared package `clock_pkg`:
  - mode encodings MODE_RUN/MODE_SET_HOUR/MODE_SET_MIN;
  - SEG_BLANK; SEG_DP bit index;
  - the 10-entry digit→segment constant table.
- One sub-module `seg7_encode`: combinational 4-bit BCD + blank input → 8-bit pattern, instantiated four times.

Test Plan (CLK_DIV=4):
- **Reset:** assert rst mid-count at 12:34:56 → outputs immediately 3F 3F 3F 3F, mode=00; btn_mode held 1 across release → no mode change.
- **Rollover:** preload 23:59:58, run 2 ticks (8 cycles) → outputs 3F 3F 3F 3F, with sec_tick pulsing once every 4 cycles.
- **Setting:**
  - mode press, then 25 inc presses → hr=1 (led1=3F, led2=06), time frozen across 40 cycles;
  - mode press, then 60 inc presses → min unchanged (wraps), hr not incremented;
  - mode press → mode=00, first advance after exactly 4 cycles.
- **Simultaneous press:** btn_mode and btn_inc rise in the same cycle in SET_HOUR → mode=10, hr unchanged.
- **DP blink:** in RUN, led2_out[7] is 1 for 2 cycles and 0 for 2 cycles per second; 0 in SET modes.
- **SET_BLINK_EN:**
  - defined, SET_MIN → led3/led4=00 for 2 cycles, digits for 2 cycles, led1/led2 steady;
  - undefined → steady.
